// File: rtl/pc_target_table_if.sv
// Lookup/write bus between decode (master) and the PC target table (slave).
interface pc_target_table_if #(
    parameter int unsigned D = 12,
    parameter int unsigned A = 3
);
    logic         lk_req;
    logic [A-1:0] lk_addr;
    logic [D-1:0] lk_pc;
    logic         lk_valid;
    logic [D-1:0] target;
    logic         target_rel;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         wr_rel;

    modport master (
        output lk_req, lk_addr, lk_pc, wr_en, wr_addr, wr_data, wr_rel,
        input  lk_valid, target, target_rel
    );

    modport slave (
        input  lk_req, lk_addr, lk_pc, wr_en, wr_addr, wr_data, wr_rel,
        output lk_valid, target, target_rel
    );
endinterface

// File: rtl/pc_target_table.sv
// Programmable branch-target table: absolute or PC-relative entries, one registered
// lookup and one write per cycle, write-first bypass on a same-index collision.
module pc_target_table #(
    parameter int unsigned D = 12,
    parameter int unsigned A = 3
) (
    input logic              Clk,
    input logic              Reset_n,
    pc_target_table_if.slave bus
);
    localparam int unsigned Depth = 2 ** A;

    function automatic logic [D-1:0] reset_val(input int unsigned idx);
        case (idx)
            0:       return D'(9);
            1:       return D'(23);
            2:       return D'(38);
            3:       return D'(53);
            4:       return D'(75);
            5:       return D'(101);
            6:       return D'(110);
            7:       return D'(125);
            default: return '0;
        endcase
    endfunction

    // Entry layout: {rel, data}.
    logic [D:0]   tbl_q [Depth];
    logic         lk_valid_q;
    logic [D-1:0] target_q, target_d;
    logic         target_rel_q, target_rel_d;
    logic [D:0]   entry;

    always_comb begin
        entry = tbl_q[bus.lk_addr];
        if (bus.wr_en && (bus.wr_addr == bus.lk_addr)) begin
            entry = {bus.wr_rel, bus.wr_data};
        end
        target_rel_d = entry[D];
        // Relative sum wraps modulo 2**D; the offset's sign is handled by the wrap.
        target_d = entry[D] ? (bus.lk_pc + entry[D-1:0]) : entry[D-1:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                tbl_q[i] <= {1'b0, reset_val(i)};
            end
        end else if (bus.wr_en) begin
            tbl_q[bus.wr_addr] <= {bus.wr_rel, bus.wr_data};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lk_valid_q   <= 1'b0;
            target_q     <= '0;
            target_rel_q <= 1'b0;
        end else begin
            lk_valid_q <= bus.lk_req;
            if (bus.lk_req) begin
                target_q     <= target_d;
                target_rel_q <= target_rel_d;
            end
        end
    end

    assign bus.lk_valid   = lk_valid_q;
    assign bus.target     = target_q;
    assign bus.target_rel = target_rel_q;
endmodule

// File: tb/tb_pc_target_table.sv
// Directed bench for pc_target_table with hand-computed expected targets.
module tb_pc_target_table;
    localparam int unsigned D = 12;
    localparam int unsigned A = 3;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    pc_target_table_if #(.D(D), .A(A)) bus ();

    pc_target_table #(.D(D), .A(A)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then advance to 1 time unit past the next rising edge.
    task automatic cycle(input logic req, input logic [A-1:0] la, input logic [D-1:0] pc,
                         input logic we, input logic [A-1:0] wa, input logic [D-1:0] wd,
                         input logic wrel);
        bus.lk_req  = req;
        bus.lk_addr = la;
        bus.lk_pc   = pc;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.wr_rel  = wrel;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [D-1:0] t,
                             input logic r);
        check_val({tag, ".valid"}, bus.lk_valid, v);
        check_val({tag, ".target"}, bus.target, t);
        check_val({tag, ".rel"}, bus.target_rel, r);
    endtask

    logic [D-1:0] rst_tgt [8];

    initial begin
        rst_tgt = '{12'd9, 12'd23, 12'd38, 12'd53, 12'd75, 12'd101, 12'd110, 12'd125};
        bus.lk_req = 0; bus.lk_addr = 0; bus.lk_pc = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_rel = 0;

        #12;
        check_out("reset", 1'b0, 12'h000, 1'b0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Back-to-back lookups over the reset contents.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, A'(i), 12'h000, 1'b0, 3'd0, 12'h000, 1'b0);
            check_out($sformatf("rst_lk%0d", i), 1'b1, rst_tgt[i], 1'b0);
        end

        // Idle holds the last target.
        cycle(1'b1, 3'd4, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("lk4", 1'b1, 12'd75, 1'b0);
        cycle(1'b0, 3'd6, 12'h123, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("idle1", 1'b0, 12'd75, 1'b0);
        cycle(1'b0, 3'd7, 12'h456, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("idle2", 1'b0, 12'd75, 1'b0);

        // Relative entries.
        cycle(1'b0, 3'd0, 12'h000, 1'b1, 3'd2, 12'h014, 1'b1);
        cycle(1'b1, 3'd2, 12'h010, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("rel_pos", 1'b1, 12'h024, 1'b1);
        cycle(1'b0, 3'd0, 12'h000, 1'b1, 3'd2, 12'hFFB, 1'b1);
        cycle(1'b1, 3'd2, 12'h004, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("rel_neg", 1'b1, 12'hFFF, 1'b1);
        cycle(1'b0, 3'd0, 12'h000, 1'b1, 3'd5, 12'h005, 1'b1);
        cycle(1'b1, 3'd5, 12'hFFE, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("rel_wrap", 1'b1, 12'h003, 1'b1);
        cycle(1'b0, 3'd0, 12'h000, 1'b1, 3'd5, 12'hFFF, 1'b1);
        cycle(1'b1, 3'd5, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("rel_m1", 1'b1, 12'hFFF, 1'b1);

        // Same-index collision bypasses; different index sees old contents.
        cycle(1'b1, 3'd3, 12'h000, 1'b1, 3'd3, 12'h200, 1'b0);
        check_out("bypass", 1'b1, 12'h200, 1'b0);
        cycle(1'b1, 3'd3, 12'h000, 1'b1, 3'd4, 12'h111, 1'b0);
        check_out("no_bypass", 1'b1, 12'h200, 1'b0);
        cycle(1'b1, 3'd4, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("wr4", 1'b1, 12'h111, 1'b0);

        // Reset with a lookup in flight, after making entry 1 relative.
        cycle(1'b1, 3'd0, 12'h000, 1'b1, 3'd1, 12'h007, 1'b1);
        check_out("pre_rst", 1'b1, 12'd9, 1'b0);
        bus.lk_req = 1'b1; bus.lk_addr = 3'd1; bus.lk_pc = 12'h100; bus.wr_en = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 12'h000, 1'b0);
        @(posedge Clk);
        #1;
        check_out("hold_rst", 1'b0, 12'h000, 1'b0);
        Reset_n = 1'b1;
        cycle(1'b1, 3'd1, 12'h100, 1'b0, 3'd0, 12'h000, 1'b0);
        check_out("post_rst", 1'b1, 12'd23, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
